ann_weight_port: RTL and testbench
==================================

// Module: ann_weight_port
// PURPOSE
//  ANN-side responder for the serial weight upload/readback protocol driven by the host or bench.
//  Captures 40 weight words streamed on Weight_in while Weight_Save_enable is high.
//  Streams stored words back on New_weight_out while Weight_Load_enable is high.
//  Gives the neuron/training core a random-access read port and a write port for updated weights.
// PARAMETERS
//  INPUT_SIZE  13    digit count; word width is INPUT_SIZE*12 = 156 bits
//  INPUT_NUM   4     temperature inputs per neuron
//  NEURON_NUM  8     hidden neurons
//  WEIGHT_NUM  INPUT_NUM*NEURON_NUM+NEURON_NUM = 40 words (derived, do not override)
// PORTS
//  Clk                 in   1    system clock, rising edge
//  Reset_l             in   1    asynchronous active-low reset
//  Weight_in           in   156  upload data word
//  Weight_Save_enable  in   1    upload strobe; one word per cycle while high
//  Weight_Load_enable  in   1    readback strobe; one word per cycle while high
//  New_weight_out      out  156  readback data word (registered)
//  Weight_valid        out  1    a complete 40-word set is stored
//  Weight_Err          out  1    sticky protocol error flag
//  Busy                out  1    high in SAVE or LOAD
//  Core_rd_addr        in   6    core read index, 0..39
//  Core_rd_data        out  156  mem[Core_rd_addr], combinational; 0 when !Weight_valid or addr>39
//  Core_wr_en          in   1    core weight update strobe
//  Core_wr_addr        in   6    core write index
//  Core_wr_data        in   156  updated weight
// BEHAVIOUR
//  Reset: state=IDLE; wr_cnt=0, rd_ptr=0; New_weight_out=0; Weight_valid=0; Weight_Err=0; Busy=0.
//   Memory contents are not reset. Reset mid-SAVE/LOAD aborts at once; the partial set is invalid.
//  FSM IDLE/SAVE/LOAD; inputs sampled on the rising edge of Clk.
//  IDLE->SAVE: Save=1 & Load=0. That edge writes mem[0]=Weight_in, sets wr_cnt=1, clears Weight_Err and Weight_valid.
//  SAVE: each edge with Save=1 and wr_cnt<40 writes mem[wr_cnt] and increments wr_cnt.
//   Save=1 with wr_cnt==40 (overrun): word dropped, Weight_Err=1.
//  SAVE->IDLE: Save=0. Weight_valid=(wr_cnt==40); if wr_cnt!=40, Weight_Err=1.
//  IDLE->LOAD: Load=1 & Save=0. That edge loads New_weight_out=mem[0] and sets rd_ptr=1.
//   First word is visible one cycle after the enable is sampled.
//  LOAD: each edge with Load=1 loads New_weight_out=mem[rd_ptr]; rd_ptr=(rd_ptr==39)?0:rd_ptr+1 (wrap).
//  LOAD->IDLE: Load=0. New_weight_out holds its last value. LOAD while !Weight_valid streams memory as-is and sets Weight_Err.
//  Save & Load both high in IDLE: stay IDLE, Weight_Err=1, no access.
//   The other enable rising inside SAVE/LOAD is ignored and sets Weight_Err=1.
//  Core write: accepted only in IDLE with Core_wr_addr<40; writes mem[addr] on the edge.
//   Otherwise dropped and Weight_Err=1. Weight_valid is unaffected.
//   Core read in the same cycle as a write to the same address returns the old data.
//  Busy=1 in SAVE and LOAD. All outputs except Core_rd_data are registered.
// STRUCTURE
//  ann_pkg: WORD_W, WEIGHT_NUM, ADDR_W=6, state enum {IDLE,SAVE,LOAD}.
//  Sub-module ann_weight_ram: 40xWORD_W, 1 write port, 2 async read ports (stream, core).
//   The FSM muxes the write port between the upload path and the core path.
// TESTING
//  Reset, then upload words 1..40, Save low -> Weight_valid=1, Err=0, Core_rd_addr=7 gives 8.
//  Load high 40 cycles -> New_weight_out=1..40, one cycle after each edge; cycle 41 -> 1 (wrap).
//  Upload only 39 words -> Weight_valid=0, Weight_Err=1; upload 41 words -> Err=1 and mem[39]=40 intact.
//  Core_wr_en addr 5 data 'hABC in IDLE -> readback word 6='hABC; same during SAVE -> dropped, Err=1.
//  Save and Load raised together -> no write, New_weight_out unchanged, Err=1.
//  Reset_l low at word 20 of upload -> all outputs 0 async; a new full upload then sets valid=1.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared constants and types for the ANN weight port: word geometry, address width, FSM states.
package ann_pkg;

    localparam int INPUT_SIZE_DEF = 13;
    localparam int INPUT_NUM_DEF  = 4;
    localparam int NEURON_NUM_DEF = 8;
    localparam int ADDR_W         = 6;

    function automatic int calc_word_w(input int input_size);
        return input_size * 12;
    endfunction

    // Input-layer weights plus one output weight per hidden neuron.
    function automatic int calc_weight_num(input int input_num, input int neuron_num);
        return input_num * neuron_num + neuron_num;
    endfunction

    localparam int WORD_W     = calc_word_w(INPUT_SIZE_DEF);
    localparam int WEIGHT_NUM = calc_weight_num(INPUT_NUM_DEF, NEURON_NUM_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        LOAD = 2'd2
    } state_t;

endpackage

// File: rtl/ann_weight_port_if.sv
// Host-side serial weight upload/readback bundle between the host (master) and the ANN port (slave).
interface ann_weight_port_if #(
    parameter int WORD_W = ann_pkg::WORD_W
);
    // Strobe protocol with no back-pressure: while Weight_Save_enable is high the port takes
    // Weight_in on every rising edge; while Weight_Load_enable is high it presents one stored
    // word per rising edge on New_weight_out, visible one cycle after the enable is sampled.
    // Raising both enables together, or the other one mid-transfer, is a protocol error.
    logic [WORD_W-1:0] Weight_in;
    logic              Weight_Save_enable;
    logic              Weight_Load_enable;
    logic [WORD_W-1:0] New_weight_out;
    logic              Weight_valid;
    logic              Weight_Err;
    logic              Busy;

    modport master (
        output Weight_in, Weight_Save_enable, Weight_Load_enable,
        input  New_weight_out, Weight_valid, Weight_Err, Busy
    );

    modport slave (
        input  Weight_in, Weight_Save_enable, Weight_Load_enable,
        output New_weight_out, Weight_valid, Weight_Err, Busy
    );

endinterface

// File: rtl/ann_weight_ram.sv
// Weight store: one synchronous write port, two asynchronous read ports (stream and core).
module ann_weight_ram #(
    parameter int DEPTH = 40,
    parameter int WIDTH = 156,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents deliberately have no reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we && (waddr <= LAST)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a <= LAST) ? mem[raddr_a] : '0;
    assign rdata_b = (raddr_b <= LAST) ? mem[raddr_b] : '0;

endmodule

// File: rtl/ann_weight_port.sv
// ANN-side responder: captures a weight set streamed by the host, streams it back on request,
// and gives the neuron/training core random read access plus an update write port.
module ann_weight_port
    import ann_pkg::*;
#(
    parameter  int INPUT_SIZE  = INPUT_SIZE_DEF,
    parameter  int INPUT_NUM   = INPUT_NUM_DEF,
    parameter  int NEURON_NUM  = NEURON_NUM_DEF,
    localparam int WORD_BITS   = calc_word_w(INPUT_SIZE),
    localparam int NUM_WEIGHTS = calc_weight_num(INPUT_NUM, NEURON_NUM)
) (
    input  logic                  Clk,
    input  logic                  Reset_l,
    ann_weight_port_if.slave      host,
    input  logic [ADDR_W-1:0]     Core_rd_addr,
    output logic [WORD_BITS-1:0]  Core_rd_data,
    input  logic                  Core_wr_en,
    input  logic [ADDR_W-1:0]     Core_wr_addr,
    input  logic [WORD_BITS-1:0]  Core_wr_data,
    output state_t                dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_W-1:0] CNT_FULL  = ADDR_W'(NUM_WEIGHTS);

    state_t state, state_nxt;

    logic                 save, load;
    logic [ADDR_W-1:0]    wr_cnt, wr_cnt_nxt;
    logic [ADDR_W-1:0]    rd_ptr, rd_ptr_nxt;
    logic [WORD_BITS-1:0] dout_q;
    logic                 dout_ld;
    logic                 valid_q, valid_nxt;
    logic                 err_q, err_nxt;
    logic                 busy_q;

    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_waddr;
    logic [WORD_BITS-1:0] ram_wdata;
    logic [ADDR_W-1:0]    strm_addr;
    logic [WORD_BITS-1:0] strm_data;
    logic [WORD_BITS-1:0] core_data;

    assign save = host.Weight_Save_enable;
    assign load = host.Weight_Load_enable;

    ann_weight_ram #(
        .DEPTH (NUM_WEIGHTS),
        .WIDTH (WORD_BITS),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (Clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (strm_addr),
        .rdata_a (strm_data),
        .raddr_b (Core_rd_addr),
        .rdata_b (core_data)
    );

    always_ff @(posedge Clk or negedge Reset_l) begin
        if (!Reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (save && !load) begin
                    state_nxt = SAVE;
                end else if (load && !save) begin
                    state_nxt = LOAD;
                end
            end
            SAVE:    if (!save) state_nxt = IDLE;
            LOAD:    if (!load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ram_we     = 1'b0;
        ram_waddr  = wr_cnt;
        ram_wdata  = host.Weight_in;
        strm_addr  = rd_ptr;
        dout_ld    = 1'b0;
        wr_cnt_nxt = wr_cnt;
        rd_ptr_nxt = rd_ptr;
        valid_nxt  = valid_q;
        err_nxt    = err_q;
        case (state)
            IDLE: begin
                if (save && load) begin
                    err_nxt = 1'b1;
                end else if (save) begin
                    ram_we     = 1'b1;
                    ram_waddr  = '0;
                    wr_cnt_nxt = ADDR_W'(1);
                    valid_nxt  = 1'b0;
                    err_nxt    = 1'b0;
                end else if (load) begin
                    strm_addr  = '0;
                    dout_ld    = 1'b1;
                    rd_ptr_nxt = (LAST_ADDR == '0) ? '0 : ADDR_W'(1);
                    if (!valid_q) err_nxt = 1'b1;
                end
                // The upload path owns the write port on the edge that starts a SAVE.
                if (Core_wr_en) begin
                    if (!ram_we && (Core_wr_addr <= LAST_ADDR)) begin
                        ram_we    = 1'b1;
                        ram_waddr = Core_wr_addr;
                        ram_wdata = Core_wr_data;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SAVE: begin
                if (save) begin
                    if (wr_cnt != CNT_FULL) begin
                        ram_we     = 1'b1;
                        ram_waddr  = wr_cnt;
                        wr_cnt_nxt = wr_cnt + 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    valid_nxt = (wr_cnt == CNT_FULL);
                    if (wr_cnt != CNT_FULL) err_nxt = 1'b1;
                end
                if (load || Core_wr_en) err_nxt = 1'b1;
            end
            LOAD: begin
                if (load) begin
                    strm_addr  = rd_ptr;
                    dout_ld    = 1'b1;
                    rd_ptr_nxt = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
                end
                if (save || Core_wr_en) err_nxt = 1'b1;
            end
            default: begin
                err_nxt = err_q;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_l) begin
        if (!Reset_l) begin
            wr_cnt  <= '0;
            rd_ptr  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            wr_cnt  <= wr_cnt_nxt;
            rd_ptr  <= rd_ptr_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            busy_q  <= (state_nxt != IDLE);
            if (dout_ld) dout_q <= strm_data;
        end
    end

    assign host.New_weight_out = dout_q;
    assign host.Weight_valid   = valid_q;
    assign host.Weight_Err     = err_q;
    assign host.Busy           = busy_q;
    assign dbg_state           = state;

    // A write on the same edge only lands after it, so a same-cycle read sees the old word.
    assign Core_rd_data = (valid_q && (Core_rd_addr <= LAST_ADDR)) ? core_data : '0;

endmodule

// File: tb/tb_ann_weight_port.sv
// Directed bench for ann_weight_port: upload, readback with wrap, core port, errors and reset abort.
module tb_ann_weight_port;
    import ann_pkg::*;

    logic                 Clk;
    logic                 Reset_l;
    logic [ADDR_W-1:0]    Core_rd_addr;
    logic [WORD_W-1:0]    Core_rd_data;
    logic                 Core_wr_en;
    logic [ADDR_W-1:0]    Core_wr_addr;
    logic [WORD_W-1:0]    Core_wr_data;
    state_t               dbg_state;

    logic [WORD_W-1:0]    exp_q[$];
    int                   n_checks;
    int                   n_errors;

    ann_weight_port_if #(.WORD_W(WORD_W)) host ();

    ann_weight_port dut (
        .Clk          (Clk),
        .Reset_l      (Reset_l),
        .host         (host),
        .Core_rd_addr (Core_rd_addr),
        .Core_rd_data (Core_rd_data),
        .Core_wr_en   (Core_wr_en),
        .Core_wr_addr (Core_wr_addr),
        .Core_wr_data (Core_wr_data),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks; all start and end on a falling edge.
    task automatic upload(input int n, input int inject);
        for (int i = 0; i < n; i++) begin
            host.Weight_Save_enable = 1'b1;
            host.Weight_in          = WORD_W'(i + 1);
            Core_wr_en              = (i == inject);
            Core_wr_addr            = ADDR_W'(5);
            Core_wr_data            = WORD_W'('hDEF);
            @(negedge Clk);
            if (i == 1) check("busy_save", host.Busy, 1);
        end
        host.Weight_Save_enable = 1'b0;
        Core_wr_en              = 1'b0;
        @(negedge Clk);
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            host.Weight_Load_enable = 1'b1;
            @(negedge Clk);
            if (i == 0) check("busy_load", host.Busy, 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL readback_queue: got empty queue expected a word");
            end else begin
                check("readback", host.New_weight_out, exp_q.pop_front());
            end
        end
        host.Weight_Load_enable = 1'b0;
        @(negedge Clk);
    endtask

    task automatic core_read(input string tag, input int addr, input logic [WORD_W-1:0] exp);
        Core_rd_addr = ADDR_W'(addr);
        #1;
        check(tag, Core_rd_data, exp);
    endtask

    initial begin
        n_checks                = 0;
        n_errors                = 0;
        Reset_l                 = 1'b0;
        host.Weight_in          = '0;
        host.Weight_Save_enable = 1'b0;
        host.Weight_Load_enable = 1'b0;
        Core_rd_addr            = '0;
        Core_wr_en              = 1'b0;
        Core_wr_addr            = '0;
        Core_wr_data            = '0;
        repeat (2) @(negedge Clk);

        check("rst_dout", host.New_weight_out, 0);
        check("rst_valid", host.Weight_valid, 0);
        check("rst_err", host.Weight_Err, 0);
        check("rst_busy", host.Busy, 0);
        check("rst_state", dbg_state, IDLE);
        Reset_l = 1'b1;
        @(negedge Clk);

        // Full upload of words 1..40
        upload(40, -1);
        check("full_valid", host.Weight_valid, 1);
        check("full_err", host.Weight_Err, 0);
        check("full_busy", host.Busy, 0);
        core_read("core_rd_7", 7, 8);
        core_read("core_rd_39", 39, 40);
        core_read("core_rd_oob", 45, 0);

        // Readback for 41 cycles: 1..40 then wrap to 1
        for (int i = 1; i <= 40; i++) exp_q.push_back(WORD_W'(i));
        exp_q.push_back(WORD_W'(1));
        readback(41);
        check("load_hold", host.New_weight_out, 1);
        check("load_err", host.Weight_Err, 0);
        check("load_busy", host.Busy, 0);

        // Core write in IDLE; same-cycle read still sees old word
        Core_rd_addr = ADDR_W'(5);
        Core_wr_en   = 1'b1;
        Core_wr_addr = ADDR_W'(5);
        Core_wr_data = WORD_W'('hABC);
        #1;
        check("core_rd_old", Core_rd_data, 6);
        @(negedge Clk);
        Core_wr_en = 1'b0;
        #1;
        check("core_wr_idle", Core_rd_data, 'hABC);
        check("core_wr_err", host.Weight_Err, 0);
        check("core_wr_valid", host.Weight_valid, 1);
        for (int i = 1; i <= 5; i++) exp_q.push_back(WORD_W'(i));
        exp_q.push_back(WORD_W'('hABC));
        readback(6);

        // Core write during SAVE is dropped
        upload(40, 10);
        check("core_save_err", host.Weight_Err, 1);
        check("core_save_valid", host.Weight_valid, 1);
        core_read("core_save_rd5", 5, 6);

        // Short upload
        upload(39, -1);
        check("short_valid", host.Weight_valid, 0);
        check("short_err", host.Weight_Err, 1);
        core_read("short_rd_gated", 7, 0);

        // Overrun upload
        upload(41, -1);
        check("over_valid", host.Weight_valid, 1);
        check("over_err", host.Weight_Err, 1);
        core_read("over_rd39", 39, 40);

        // Both enables together in IDLE
        upload(40, -1);
        check("clean_err", host.Weight_Err, 0);
        host.Weight_in          = WORD_W'('h999);
        host.Weight_Save_enable = 1'b1;
        host.Weight_Load_enable = 1'b1;
        @(negedge Clk);
        host.Weight_Save_enable = 1'b0;
        host.Weight_Load_enable = 1'b0;
        @(negedge Clk);
        check("both_err", host.Weight_Err, 1);
        check("both_dout", host.New_weight_out, 'hABC);
        check("both_state", dbg_state, IDLE);
        check("both_valid", host.Weight_valid, 1);
        core_read("both_rd0", 0, 1);

        // Asynchronous reset after 20 words of an upload
        @(negedge Clk);
        for (int i = 0; i < 20; i++) begin
            host.Weight_Save_enable = 1'b1;
            host.Weight_in          = WORD_W'(i + 1);
            @(negedge Clk);
        end
        #2;
        Reset_l                 = 1'b0;
        host.Weight_Save_enable = 1'b0;
        #1;
        check("arst_dout", host.New_weight_out, 0);
        check("arst_valid", host.Weight_valid, 0);
        check("arst_err", host.Weight_Err, 0);
        check("arst_busy", host.Busy, 0);
        check("arst_state", dbg_state, IDLE);
        @(negedge Clk);
        Reset_l = 1'b1;
        @(negedge Clk);

        // LOAD with no valid set streams memory as-is and flags an error
        exp_q.push_back(WORD_W'(1));
        readback(1);
        check("inv_load_err", host.Weight_Err, 1);
        check("inv_load_valid", host.Weight_valid, 0);

        // New full upload after the abort
        upload(40, -1);
        check("reup_valid", host.Weight_valid, 1);
        check("reup_err", host.Weight_Err, 0);
        core_read("reup_rd0", 0, 1);
        core_read("reup_rd25", 25, 26);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
